mod_counter_ctrl: RTL and testbench

//   Parametrised programmable-modulus counter for the game timing chain: tile

---
 rtl/mod_counter_ctrl.sv | 76 +++++++
 tb/tb_mod_counter_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mod_counter_ctrl.sv
// mod_counter_ctrl: programmable-modulus up/down counter with pause, load, tick qualification,
// terminal-count pulse and saturating wrap tally
module mod_counter_ctrl #(
  parameter int WIDTH  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              tick_en,
  input  logic              dir,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  modulus,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic [WRAP_W-1:0] wraps,
  output logic              running
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, top;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic tc_q, tc_d, wrap;
  assign top = (modulus == '0) ? '1 : modulus - WIDTH'(1);
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wraps_d = wraps_q;
    tc_d    = 1'b0;
    wrap    = 1'b0;
    if (!start) begin
      state_d = IDLE;
      count_d = '0;
      wraps_d = '0;
    end else if (state_q == IDLE) begin
      state_d = pause ? PAUSED : RUN;
    end else if (load) begin
      count_d = (load_val > top) ? top : load_val;
    end else if (pause) begin
      state_d = PAUSED;
    end else begin
      state_d = RUN;
      // leaving PAUSED takes one edge before ticks are honoured again
      if (state_q == RUN && tick_en) begin
        if (!dir) begin
          wrap    = count_q >= top;
          count_d = wrap ? '0 : count_q + WIDTH'(1);
        end else begin
          wrap    = count_q == '0;
          count_d = (wrap || count_q > top) ? top : count_q - WIDTH'(1);
        end
        tc_d    = wrap;
        wraps_d = (wrap && wraps_q != '1) ? wraps_q + WRAP_W'(1) : wraps_q;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      wraps_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wraps_q <= wraps_d;
      tc_q    <= tc_d;
    end
  end
  assign count   = count_q;
  assign tc      = tc_q;
  assign wraps   = wraps_q;
  assign running = state_q == RUN;
endmodule

// File: tb/tb_mod_counter_ctrl.sv
// tb_mod_counter_ctrl: directed table and sequence checks of mod_counter_ctrl
module tb_mod_counter_ctrl;
  logic clk = 0, reset = 1, start = 0, pause = 0, tick_en = 0, dir = 0, load = 0;
  logic [7:0] load_val = 0, modulus = 0;
  logic [7:0] count, count2;
  logic tc, tc2, running, running2;
  logic [7:0] wraps;
  logic [1:0] wraps2;
  int checks = 0, failures = 0;

  mod_counter_ctrl u0 (.clk(clk), .reset(reset), .start(start), .pause(pause), .tick_en(tick_en),
    .dir(dir), .load(load), .load_val(load_val), .modulus(modulus), .count(count), .tc(tc),
    .wraps(wraps), .running(running));
  mod_counter_ctrl #(.WIDTH(8), .WRAP_W(2)) u1 (.clk(clk), .reset(reset), .start(start),
    .pause(pause), .tick_en(tick_en), .dir(dir), .load(load), .load_val(load_val),
    .modulus(modulus), .count(count2), .tc(tc2), .wraps(wraps2), .running(running2));

  always #5 clk = ~clk;

  typedef struct {
    logic st, pa, tk, dr, ld;
    logic [7:0] lv, md, c;
    logic t;
    logic [7:0] w;
    logic r;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, pa, tk, dr, ld, input logic [7:0] lv, md);
    start = st; pause = pa; tick_en = tk; dir = dr; load = ld; load_val = lv; modulus = md;
  endtask

  initial begin
    tbl[0]  = '{1,0,1,1,0, 0,4, 0,0,0,1};
    tbl[1]  = '{1,0,1,1,0, 0,4, 3,1,1,1};
    tbl[2]  = '{1,0,1,1,0, 0,4, 2,0,1,1};
    tbl[3]  = '{1,0,1,1,0, 0,4, 1,0,1,1};
    tbl[4]  = '{1,0,1,1,0, 0,4, 0,0,1,1};
    tbl[5]  = '{1,0,1,1,0, 0,4, 3,1,2,1};
    tbl[6]  = '{0,0,0,0,0, 0,4, 0,0,0,0};
    tbl[7]  = '{0,0,0,0,1, 3,4, 0,0,0,0};
    tbl[8]  = '{1,1,0,0,0, 0,6, 0,0,0,0};
    tbl[9]  = '{1,1,1,0,1, 9,6, 5,0,0,0};
    tbl[10] = '{1,0,1,1,0, 0,3, 5,0,0,1};
    tbl[11] = '{1,0,1,1,0, 0,3, 2,0,0,1};
    tbl[12] = '{1,0,1,0,0, 0,3, 0,1,1,1};
    tbl[13] = '{1,0,1,0,1, 7,3, 2,0,1,1};
    tbl[14] = '{0,0,1,0,0, 0,3, 0,0,0,0};

    step();
    step();
    chk("rst_count", count, 0);
    chk("rst_tc", tc, 0);
    chk("rst_wraps", wraps, 0);
    chk("rst_running", running, 0);
    reset = 0;

    // full-range up count, modulus 0
    drive(1, 0, 1, 0, 0, 0, 0);
    step();
    chk("t1_enter_run", running, 1);
    chk("t1_enter_count", count, 0);
    for (int i = 1; i <= 256; i++) begin
      step();
      chk($sformatf("t1_count%0d", i), count, i % 256);
      chk($sformatf("t1_tc%0d", i), tc, (i == 256) ? 1 : 0);
    end
    chk("t1_wraps", wraps, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].st, tbl[i].pa, tbl[i].tk, tbl[i].dr, tbl[i].ld, tbl[i].lv, tbl[i].md);
      step();
      chk($sformatf("tbl%0d_count", i), count, tbl[i].c);
      chk($sformatf("tbl%0d_tc", i), tc, tbl[i].t);
      chk($sformatf("tbl%0d_wraps", i), wraps, tbl[i].w);
      chk($sformatf("tbl%0d_running", i), running, tbl[i].r);
    end

    // modulus 5, tick every third clock, then pause at count 2
    drive(1, 0, 0, 0, 0, 0, 5);
    step();
    for (int t = 1; t <= 7; t++) begin
      tick_en = 0;
      step();
      step();
      chk($sformatf("t2_hold%0d", t), count, (t - 1) % 5);
      chk($sformatf("t2_holdtc%0d", t), tc, 0);
      tick_en = 1;
      step();
      chk($sformatf("t2_count%0d", t), count, t % 5);
      chk($sformatf("t2_tc%0d", t), tc, (t == 5) ? 1 : 0);
    end
    pause = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t2_paused%0d", k), count, 2);
      chk($sformatf("t2_paused_run%0d", k), running, 0);
    end
    pause = 0;
    step();
    chk("t2_resume_count", count, 2);
    chk("t2_resume_run", running, 1);
    step();
    chk("t2_after_resume", count, 3);
    chk("t2_wraps", wraps, 1);
    start = 0;
    step();

    // modulus 1: every advance wraps; 2-bit tally saturates
    drive(1, 0, 1, 0, 0, 0, 1);
    step();
    chk("t5_enter_tc", tc, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("t5_tc%0d", k), tc, 1);
      chk($sformatf("t5_count%0d", k), count, 0);
      chk($sformatf("t5_wraps2_%0d", k), wraps2, (k > 3) ? 3 : k);
      chk($sformatf("t5_wraps8_%0d", k), wraps, k);
    end
    start = 0;
    step();

    // asynchronous reset mid-count
    drive(1, 0, 1, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 4; k++) step();
    chk("t6_pre_count", count, 4);
    #2 reset = 1;
    #1;
    chk("t6_count", count, 0);
    chk("t6_wraps", wraps, 0);
    chk("t6_tc", tc, 0);
    chk("t6_running", running, 0);
    #1 reset = 0;
    step();
    chk("t6_restart_count", count, 0);
    chk("t6_restart_run", running, 1);
    step();
    chk("t6_first_adv", count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
